// File: rtl/byte_read_serializer.sv
// Latches a SIZE_IN_BYTES*8-bit word and streams it out one byte per valid/ready beat with a byte index.
// Optional macro BYTE_READ_MSB_FIRST_EN: when defined, the most significant byte is sent first.
module byte_read_serializer #(
   parameter int SIZE_IN_BYTES = 12,
   parameter int BYTE_NUM_SIZE = 16
) (
   input  logic                       CLK,
   input  logic                       ARESET,
   input  logic                       LOAD_VALID,
   output logic                       LOAD_READY,
   input  logic [SIZE_IN_BYTES*8-1:0] LOAD_VALUE,
   input  logic                       ABORT,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [7:0]                 OUTPUT_VALUE,
   output logic [BYTE_NUM_SIZE-1:0]   BYTE_NUM,
   output logic                       OUT_LAST,
   output logic                       BUSY
);

   localparam logic [BYTE_NUM_SIZE-1:0] LAST_IDX = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);

   if (SIZE_IN_BYTES < 1) begin : g_bad_size
      $error("SIZE_IN_BYTES must be at least 1");
   end
   if ((BYTE_NUM_SIZE < 31) && ((64'd1 << BYTE_NUM_SIZE) < 64'(SIZE_IN_BYTES))) begin : g_bad_idx
      $error("BYTE_NUM_SIZE too narrow for SIZE_IN_BYTES");
   end

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                       state_q, state_d;
   logic [SIZE_IN_BYTES*8-1:0]   word_q, word_d;
   logic [BYTE_NUM_SIZE-1:0]     cnt_q, cnt_d;

   // NOTE: ARESET is synchronous, so it is sampled only on the clock edge and stays out of the event list.
   always_ff @(posedge CLK) begin
      if (!ARESET) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      LOAD_READY = 1'b0;
      OUT_VALID  = 1'b0;
      OUT_LAST   = 1'b0;
      BUSY       = 1'b0;
      case (state_q)
         IDLE: begin
            LOAD_READY = 1'b1;
            if (LOAD_VALID) begin
               word_d  = LOAD_VALUE;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            OUT_VALID = 1'b1;
            BUSY      = 1'b1;
            OUT_LAST  = (cnt_q == LAST_IDX);
            // Abort outranks a coincident handshake; that beat is still considered delivered.
            if (ABORT) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (OUT_READY) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + BYTE_NUM_SIZE'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign BYTE_NUM = cnt_q;

   // Byte select driven purely from registered word and counter.
   always_comb begin
      OUTPUT_VALUE = '0;
      for (int k = 0; k < SIZE_IN_BYTES; k++) begin
         if (cnt_q == BYTE_NUM_SIZE'(k)) begin
`ifdef BYTE_READ_MSB_FIRST_EN
            OUTPUT_VALUE = word_q[(SIZE_IN_BYTES-1-k)*8 +: 8];
`else
            OUTPUT_VALUE = word_q[k*8 +: 8];
`endif
         end
      end
   end

endmodule
